// File: rtl/resource_pkg.sv
// Shared constants and types for the resource arbiter: pool/op codes, widths, FSM states.
package resource_pkg;

  localparam int DP_W     = 8;
  localparam int ENERGY_W = 8;
  localparam int TRACER_W = 6;
  localparam int FLUID_W  = 4;

  localparam logic [DP_W-1:0] ENERGY_MAX = DP_W'((1 << ENERGY_W) - 1);
  localparam logic [DP_W-1:0] TRACER_MAX = DP_W'((1 << TRACER_W) - 1);
  localparam logic [DP_W-1:0] FLUID_MAX  = DP_W'((1 << FLUID_W) - 1);

  typedef enum logic [1:0] {
    POOL_ENERGY = 2'd0,
    POOL_TRACER = 2'd1,
    POOL_FLUID  = 2'd2,
    POOL_RSVD   = 2'd3
  } pool_t;

  localparam logic OP_REFILL  = 1'b0;
  localparam logic OP_CONSUME = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/resource_arbiter_if.sv
// Requester-side bundle: per-requester request fields, acknowledge and pool read-back.
interface resource_arbiter_if #(parameter int NREQ = 4);
  import resource_pkg::*;

  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   req_pool;
  logic [NREQ-1:0]     req_op;
  logic [8*NREQ-1:0]   req_amt;
  logic [NREQ-1:0]     ack;
  logic                ok;
  logic                busy;
  logic [ENERGY_W-1:0] energy;
  logic [TRACER_W-1:0] tracer;
  logic [FLUID_W-1:0]  fluid;

  modport master (
    output req, req_pool, req_op, req_amt,
    input  ack, ok, busy, energy, tracer, fluid
  );

  modport slave (
    input  req, req_pool, req_op, req_amt,
    output ack, ok, busy, energy, tracer, fluid
  );

endinterface

// File: rtl/addsub8.sv
// Eight-bit adder/subtractor: cin=1 subtracts by adding inverted b plus the carry-in.
module addsub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] b_eff;

  assign b_eff       = cin ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// Shares one adder/subtractor among NREQ requesters to consume from or refill three pools.
module resource_arbiter
  import resource_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  resource_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, gnt_idx, idx_p0;
  logic [NREQ-1:0]     gnt;
  logic                gnt_any;
  pool_t               pool_p0;
  logic                op_p0;
  logic [DP_W-1:0]     amt_p0, a_ext, max_sel, sum, sum_p1;
  logic                cout, cout_p1;
  logic [DP_W:0]       settle_res;
  logic                ok_nxt;
  logic [ENERGY_W-1:0] energy_q;
  logic [TRACER_W-1:0] tracer_q;
  logic [FLUID_W-1:0]  fluid_q;
  logic [NREQ-1:0]     ack_q;
  logic                ok_q;

  // Returns {ok, new pool value}; a borrow denies a consume, a refill clamps at the pool maximum.
  function automatic logic [DP_W:0] settle(input logic [DP_W-1:0] cur, input logic [DP_W-1:0] s,
                                           input logic c, input logic op, input logic [DP_W-1:0] maxv);
    if (op == OP_CONSUME) return c ? {1'b1, s} : {1'b0, cur};
    if (c || (s > maxv)) return {1'b1, maxv};
    return {1'b1, s};
  endfunction

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  addsub8 u_dp (
    .a    (a_ext),
    .b    (amt_p0),
    .cin  (op_p0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_any) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    a_ext   = '0;
    max_sel = '0;
    case (pool_p0)
      POOL_ENERGY: begin a_ext = energy_q;          max_sel = ENERGY_MAX; end
      POOL_TRACER: begin a_ext = DP_W'(tracer_q);   max_sel = TRACER_MAX; end
      POOL_FLUID:  begin a_ext = DP_W'(fluid_q);    max_sel = FLUID_MAX;  end
      default:     begin a_ext = '0;                max_sel = '0;         end
    endcase
  end

  assign settle_res = settle(a_ext, sum_p1, cout_p1, op_p0, max_sel);
  assign ok_nxt     = (pool_p0 != POOL_RSVD) && settle_res[DP_W];

  // Grant stage: latch the winner's fields; exec stage: register the datapath result.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && gnt_any) begin
      pool_p0 <= pool_t'(bus.req_pool[2*int'(gnt_idx) +: 2]);
      op_p0   <= bus.req_op[gnt_idx];
      amt_p0  <= bus.req_amt[8*int'(gnt_idx) +: 8];
    end
    if (state == S_EXEC) begin
      sum_p1  <= sum;
      cout_p1 <= cout;
    end
  end

  // Done stage: write back, acknowledge, advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      idx_p0   <= '0;
      ack_q    <= '0;
      ok_q     <= 1'b0;
      energy_q <= '1;
      tracer_q <= '1;
      fluid_q  <= '1;
    end else begin
      state <= state_nxt;
      ack_q <= '0;
      ok_q  <= 1'b0;
      if (state == S_IDLE && gnt_any) idx_p0 <= gnt_idx;
      if (state == S_DONE) begin
        ack_q[idx_p0] <= 1'b1;
        ok_q          <= ok_nxt;
        ptr           <= (idx_p0 == IW'(NREQ - 1)) ? '0 : idx_p0 + 1'b1;
        if (ok_nxt) begin
          case (pool_p0)
            POOL_ENERGY: energy_q <= settle_res[ENERGY_W-1:0];
            POOL_TRACER: tracer_q <= settle_res[TRACER_W-1:0];
            POOL_FLUID:  fluid_q  <= settle_res[FLUID_W-1:0];
            default:     ;
          endcase
        end
      end
    end
  end

  assign bus.ack    = ack_q;
  assign bus.ok     = ok_q;
  assign bus.busy   = (state != S_IDLE) || (|ack_q);
  assign bus.energy = energy_q;
  assign bus.tracer = tracer_q;
  assign bus.fluid  = fluid_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter: single transactions, saturation/denial, round-robin, reset abort.
module tb_resource_arbiter;

  localparam int NREQ = 4;
  localparam int PE = 0, PT = 1, PF = 2, PR = 3;
  localparam int REF = 0, CONS = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  resource_arbiter_if #(.NREQ(NREQ)) bus ();

  resource_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input int pool, input int op, input int amt);
    bus.req_pool[2*r +: 2] = 2'(pool);
    bus.req_op[r]          = 1'(op);
    bus.req_amt[8*r +: 8]  = 8'(amt);
    bus.req[r]             = 1'b1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.ack == '0 && lat < 20);
  endtask

  task automatic txn(input string tag, input int r, input int pool, input int op, input int amt,
                     input logic exp_ok);
    int lat;
    set_req(r, pool, op, amt);
    wait_ack(lat);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_ack"}, bus.ack, 32'(1 << r));
    chk({tag, "_ok"}, bus.ok, exp_ok);
    bus.req[r] = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_pool = '0;
    bus.req_op   = '0;
    bus.req_amt  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_energy", bus.energy, 255);
    chk("rst_tracer", bus.tracer, 63);
    chk("rst_fluid", bus.fluid, 15);
    chk("rst_ack", bus.ack, 0);
    chk("rst_ok", bus.ok, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.ack != '0 || bus.busy !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // First consume traced cycle by cycle.
    set_req(0, PE, CONS, 100);
    tick();
    chk("c1_busy_e0", bus.busy, 1);
    chk("c1_ack_e0", bus.ack, 0);
    chk("c1_energy_e0", bus.energy, 255);
    tick();
    chk("c1_busy_e1", bus.busy, 1);
    chk("c1_ack_e1", bus.ack, 0);
    tick();
    chk("c1_ack_e2", bus.ack, 1);
    chk("c1_ok_e2", bus.ok, 1);
    chk("c1_busy_e2", bus.busy, 1);
    chk("c1_energy_e2", bus.energy, 155);
    bus.req[0] = 1'b0;
    tick();
    chk("c1_busy_e3", bus.busy, 0);
    chk("c1_ack_e3", bus.ack, 0);
    chk("c1_ok_e3", bus.ok, 0);

    txn("deny200", 0, PE, CONS, 200, 1'b0);
    chk("deny200_energy", bus.energy, 155);
    txn("fl_c10", 1, PF, CONS, 10, 1'b1);
    chk("fl_c10_val", bus.fluid, 5);
    txn("fl_r20", 2, PF, REF, 20, 1'b1);
    chk("fl_r20_sat", bus.fluid, 15);
    txn("tr_r0", 3, PT, REF, 0, 1'b1);
    chk("tr_r0_val", bus.tracer, 63);
    txn("en_r50", 0, PE, REF, 50, 1'b1);
    chk("en_r50_val", bus.energy, 205);
    txn("fl_c15", 1, PF, CONS, 15, 1'b1);
    chk("fl_c15_val", bus.fluid, 0);
    txn("fl_c1", 2, PF, CONS, 1, 1'b0);
    chk("fl_c1_val", bus.fluid, 0);
    txn("fl_r15", 3, PF, REF, 15, 1'b1);
    chk("fl_r15_val", bus.fluid, 15);
    txn("tr_c200", 0, PT, CONS, 200, 1'b0);
    chk("tr_c200_val", bus.tracer, 63);
    txn("en_c0", 1, PE, CONS, 0, 1'b1);
    chk("en_c0_val", bus.energy, 205);
    txn("en_r255", 2, PE, REF, 255, 1'b1);
    chk("en_r255_sat", bus.energy, 255);
    txn("en_c55", 3, PE, CONS, 55, 1'b1);
    chk("en_c55_val", bus.energy, 200);

    // All requesters held high, pointer at 0.
    for (int r = 0; r < NREQ; r++) set_req(r, PT, CONS, 1);
    for (int k = 0; k < 8; k++) begin
      wait_ack(lat);
      chk($sformatf("rr%0d_lat", k), lat, 3);
      chk($sformatf("rr%0d_ack", k), bus.ack, 32'(1 << (k % NREQ)));
      chk($sformatf("rr%0d_ok", k), bus.ok, 1);
      chk($sformatf("rr%0d_tracer", k), bus.tracer, 32'(62 - k));
      if (k == 7) bus.req = '0;
    end

    txn("rsvd", 1, PR, CONS, 5, 1'b0);
    chk("rsvd_energy", bus.energy, 200);
    chk("rsvd_tracer", bus.tracer, 55);
    chk("rsvd_fluid", bus.fluid, 15);

    // Abort a consume while it is executing.
    set_req(2, PE, CONS, 50);
    tick();
    chk("abort_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_energy", bus.energy, 255);
    chk("abort_tracer", bus.tracer, 63);
    chk("abort_busy_low", bus.busy, 0);
    bus.req[2] = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.ack != '0) bad++;
    end
    chk("abort_no_ack", bad, 0);
    #2;
    rst_n = 1'b1;
    set_req(1, PE, CONS, 50);
    set_req(3, PT, CONS, 1);
    wait_ack(lat);
    chk("post_lat", lat, 3);
    chk("post_ack1", bus.ack, 2);
    chk("post_energy", bus.energy, 205);
    bus.req[1] = 1'b0;
    wait_ack(lat);
    chk("post_ack3", bus.ack, 8);
    chk("post_tracer", bus.tracer, 62);
    bus.req[3] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/resource_arbiter.md
# resource_arbiter

Controller that shares one eight-bit adder/subtractor among NREQ requesters to consume from or refill three resource pools: energy (8 b), tracer (6 b), fluid (4 b). It owns the pool registers, picks one request at a time round-robin, and runs the add or subtract through the shared datapath. It rejects consumes that would underflow and saturates refills. It sits between the suit subsystems (requesters) and the resource state they read.

## Interface
- NREQ, 4, number of requesters (2..8)
- ENERGY_W, 8, energy pool width (fixed, equals datapath width)
- TRACER_W, 6, tracer pool width
- FLUID_W, 4, fluid pool width

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req  in  NREQ  per-requester request, level; held until matching ack
- req_pool  in  2*NREQ  pool select per requester: 0 energy, 1 tracer, 2 fluid, 3 reserved
- req_op  in  NREQ  0 = refill (add), 1 = consume (subtract)
- req_amt  in  8*NREQ  amount per requester, unsigned
- ack  out  NREQ  one-hot, one-cycle pulse completing the granted request
- ok  out  1  valid only while ack is nonzero: 1 = applied, 0 = denied
- busy  out  1  high from the cycle after a grant through the ack cycle
- energy  out  ENERGY_W  current energy pool
- tracer  out  TRACER_W  current tracer pool
- fluid  out  FLUID_W  current fluid pool

## Operation
- Reset state: IDLE, ack=0, ok=0, busy=0, round-robin pointer=0, all pools full (all ones: 255/63/15).
- FSM IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: if any req is set, grant the first set bit at or after the pointer, searching upward and wrapping. Latch index, pool, op and amt. Go to EXEC.
  - EXEC: drive the datapath with a = zero-extended selected pool, b = amt, cin = op. Register sum and cout.
  - DONE: write the pool, pulse ack[index], drive ok, set pointer = index+1 mod NREQ, return to IDLE.
- Consume: cout=0 (borrow) means deny. Pool is unchanged and ok=0. Otherwise pool = sum[W-1:0] and ok=1.
- Refill: if cout=1 or sum > 2^W-1, pool saturates to 2^W-1; otherwise pool = sum. ok=1 in both cases.
- amt = 0: ok=1, pool unchanged for both ops.
- For narrow pools, a consume amount larger than the pool is denied by the same borrow rule. No truncation of amt.
- Reserved pool code 3: no datapath effect, ok=0.
- Inputs of non-granted requesters are ignored. Their req stays pending.
- Requester handshake rules:
  - Deassert req in the cycle after ack.
  - A req still high in the IDLE cycle after DONE counts as a new request, subject to round-robin.
  - Fields of the granted requester must be stable from grant to ack. Only the latched copy is used.

## Timing
- Request visible in IDLE at edge N: grant at N, ack and pool update visible after edge N+2, i.e. 3 cycles request-to-ack.
- Back-to-back throughput is one transaction per 3 cycles.
- Pool outputs are registers and change only on the DONE edge.
- busy rises after edge N and falls after edge N+3.
- Async reset mid-transaction: the transaction is abandoned with no ack, pools return to full, and the pointer returns to 0. Deassertion is synchronized externally.
- Simultaneous requests: exactly one grant per IDLE cycle. No starvation; worst-case wait is NREQ transactions.

## Structure
- Package resource_pkg holds:
  - pool codes (POOL_ENERGY, POOL_TRACER, POOL_FLUID, POOL_RSVD)
  - op codes (OP_REFILL, OP_CONSUME)
  - the FSM state enum
  - the width constants
- Sub-module rr_arbiter: round-robin, combinational grant from req and pointer, with one-hot output and a binary index.
- Datapath: exactly one instance of the team's existing eight-bit adder/subtractor (a, b, cin, cout, sum; cin=1 subtracts via inverted b plus carry-in). It must not be duplicated per pool.

## Test plan
- Reset then idle: energy=255, tracer=63, fluid=15; ack=0, busy=0 for 10 cycles.
- Req0 consumes energy 100: ack[0] exactly 3 cycles later, ok=1, energy=155. A second consume of 200 is denied (ok=0, energy stays 155).
- Refill with fluid=15 minus 10 = 5, then refill 20: ok=1, fluid saturates to 15. Refill tracer 0 leaves tracer=63 with ok=1.
- All 4 requesters held high continuously, each consuming tracer 1: acks in order 0,1,2,3,0,…, one every 3 cycles, tracer decrements by 1 per ack.
- Pool code 3 request: ack with ok=0, all pools unchanged.
- Assert rst_n low during EXEC of a consume of 50: no ack issued, energy reads 255 immediately, the next request is granted starting from requester 0.
